gen_a_multi: RTL and testbench
==============================

Name: gen_a_multi

Overview:
Parametrised rejection sampler that expands a seed into NUM_POLY uniform polynomials of N coefficients each. It loads the seed from the seed RAM and reseeds the Trivium PRNG once per polynomial, using per-polynomial domain separation. It then parses PRNG blocks lane by lane, rejecting coefficients at or above Q_BOUND, and writes accepted coefficients to the polynomial RAM. It sits between the seed RAM, the Trivium PRNG (rdi interface) and the poly RAM, and supersedes the single-polynomial generator.

Parameters:
N, 512, coefficients per polynomial (power of 2)
NUM_POLY, 1, polynomials generated per start (1..16)
COEF_W, 16, coefficient/lane width in bits
RDI_W, 128, PRNG block width; must be a multiple of COEF_W; LANES = RDI_W/COEF_W
SEED_WORDS, 8, 32-bit seed words; seed width SW = 32*SEED_WORDS
Q_BOUND, 61445, rejection bound (5q); accept iff lane < Q_BOUND

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse; begin generation (ignored unless idle)
done  out  1  one-cycle pulse when the final coefficient is written
busy  out  1  high from the cycle after an accepted start until done
byte_addr  out  clog2(SEED_WORDS)  seed RAM read address
byte_do  in  32  seed RAM read data, 1-cycle read latency
seed  out  SW  seed presented to PRNG
reseed  out  1  reseed request, level
reseed_ack  in  1  PRNG accepted seed
rdi_data  in  RDI_W  PRNG block
rdi_valid  in  1  PRNG block valid
rdi_ready  out  1  sampler ready for block
poly_wea  out  1  poly RAM write enable
poly_addra  out  clog2(N*NUM_POLY)  write address, {poly index, coefficient index}
poly_dia  out  COEF_W  write data
rej_cnt  out  16  lanes rejected in current run, saturating

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; counters and buffer cleared. Reset mid-operation abandons the run; no done.
- States: IDLE, LOAD_SEED, RESEED, WAIT_RDI, PARSE. All outputs are registered.
- IDLE: when start=1, clear rej_cnt, set poly index p=0, go to LOAD_SEED. start in any other state is ignored.
- LOAD_SEED: issue addresses 0..SEED_WORDS-1 on consecutive cycles. Word k returns one cycle later and is captured into seed[32k+:32]. This takes SEED_WORDS+1 cycles, then go to RESEED.
- RESEED: seed[SW-1:SW-8] ^= p (applied against the loaded value, not cumulatively). Hold reseed=1 until reseed_ack=1. reseed drops the cycle after ack, then go to WAIT_RDI. If ack arrives in the first cycle reseed is high, that is still a single handshake.
- WAIT_RDI: rdi_ready=1. A transfer occurs when rdi_valid & rdi_ready; the block is captured into buf, rdi_ready drops the next cycle, and the state goes to PARSE with lane i=0. rdi_valid without rdi_ready is ignored.
- PARSE: one lane per cycle. lane i = buf[i*COEF_W+:COEF_W] (lane 0 = LSBs).
  - Accept: the next cycle has poly_wea=1, poly_addra={p, ctr}, poly_dia=lane; then ctr++.
  - Reject: rej_cnt++, saturating at 0xFFFF.
- End of polynomial: on the accept with ctr==N-1, ctr wraps to 0 and remaining lanes are discarded.
  - If p<NUM_POLY-1: p++ and go to RESEED. The seed RAM is not reread; the loaded seed is kept.
  - Else: done=1 in the same cycle as the final poly_wea, then IDLE.
- After lane LANES-1 without completion, go to WAIT_RDI.
- Throughput: at most one write per cycle; poly_wea is never asserted outside PARSE+1.
- lane == Q_BOUND is rejected; lane == Q_BOUND-1 is accepted.

Decomposition:
- Shared package newhope_pkg: NEWHOPE_Q=12289, NEWHOPE_5Q=61445, gen-state enum, clog2 helper.
- Sub-module gen_a_lane_buf: captures an RDI_W block on handshake, presents lane i, and outputs the accept flag (lane < Q_BOUND) plus the last-lane flag.

Test Plan:
- N=16, NUM_POLY=1: PRNG blocks with all lanes 0x0000..0x0007 and 0x0008..0x000F -> 16 writes, addr 0..15, data = addr, done coincident with the addr-15 write, rej_cnt=0.
- Lanes alternating 0xF005/0xF004 -> only 0xF004 written, rej_cnt increments once per 0xF005, 0xFFFF rejected.
- Seed RAM word k = 0x01010101*(k+1), reseed_ack delayed 5 cycles -> seed equals the concatenation of the words, reseed held exactly until ack, no early rdi_ready.
- N=16, NUM_POLY=2 -> second reseed with seed[255:248] = word7 top byte ^ 0x01, addresses 16..31 for poly 1, single done.
- rdi_valid low for 10 cycles mid-run, then reset asserted during PARSE -> no writes while stalled, all outputs 0 immediately on reset, no done.
- start pulsed while busy -> ignored; the run completes with the unchanged write count.

Source files
------------

// File: rtl/newhope_pkg.sv
// Shared constants, generator state encoding and width helpers for the
// NewHope uniform-polynomial generators.
package newhope_pkg;

    localparam int NEWHOPE_Q  = 12289;
    localparam int NEWHOPE_5Q = 5 * NEWHOPE_Q;

    typedef enum logic [2:0] {
        GS_IDLE      = 3'd0,
        GS_LOAD_SEED = 3'd1,
        GS_RESEED    = 3'd2,
        GS_WAIT_RDI  = 3'd3,
        GS_PARSE     = 3'd4
    } gen_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = 1;
        while (v < value) begin
            v   = v * 2;
            res = res + 1;
        end
        return res;
    endfunction

    // Ceiling log2 clamped to 1 so that it can size a vector.
    function automatic int clog2_min1(input int value);
        int r;
        r = clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gen_a_lane_buf.sv
// Holds one PRNG block and presents it one coefficient lane at a time,
// together with the rejection decision for that lane.
module gen_a_lane_buf
    import newhope_pkg::*;
#(
    parameter int COEF_W  = 16,
    parameter int RDI_W   = 128,
    parameter int Q_BOUND = NEWHOPE_5Q,
    parameter int LW      = clog2_min1(RDI_W / COEF_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RDI_W-1:0]  rdi_data,
    input  logic [LW-1:0]     lane_idx,
    output logic [COEF_W-1:0] lane,
    output logic              accept,
    output logic              last
);

    localparam int LANES = RDI_W / COEF_W;
    localparam logic [COEF_W:0] QB = (COEF_W + 1)'(Q_BOUND);

    logic [RDI_W-1:0]  buf_q;
    logic [COEF_W-1:0] lanes [LANES];

    // Capture a whole block when the PRNG handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= rdi_data;
        end
    end

    // Split the block into lanes (lane 0 in the LSBs) and select the current one.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lanes[i] = buf_q[i*COEF_W +: COEF_W];
        end
        lane   = lanes[lane_idx];
        accept = ({1'b0, lane} < QB);
        last   = (lane_idx == LW'(LANES - 1));
    end

endmodule

// File: rtl/gen_a_multi.sv
// Rejection sampler expanding one seed into NUM_POLY uniform polynomials.
// The seed is read once; each polynomial reseeds the PRNG with the top seed
// byte xored with the polynomial index.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start
// LOAD_SEED | reading seed words 0..SEED_WORDS-1 (one extra cycle for latency)
// RESEED    | reseed held high until the PRNG acknowledges
// WAIT_RDI  | rdi_ready high, waiting for a PRNG block
// PARSE     | one lane per cycle, accepted lanes written to the poly RAM
module gen_a_multi
    import newhope_pkg::*;
#(
    parameter int N          = 512,
    parameter int NUM_POLY   = 1,
    parameter int COEF_W     = 16,
    parameter int RDI_W      = 128,
    parameter int SEED_WORDS = 8,
    parameter int Q_BOUND    = NEWHOPE_5Q
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 done,
    output logic                                 busy,
    output logic [clog2_min1(SEED_WORDS)-1:0]    byte_addr,
    input  logic [31:0]                          byte_do,
    output logic [32*SEED_WORDS-1:0]             seed,
    output logic                                 reseed,
    input  logic                                 reseed_ack,
    input  logic [RDI_W-1:0]                     rdi_data,
    input  logic                                 rdi_valid,
    output logic                                 rdi_ready,
    output logic                                 poly_wea,
    output logic [clog2_min1(N*NUM_POLY)-1:0]    poly_addra,
    output logic [COEF_W-1:0]                    poly_dia,
    output logic [15:0]                          rej_cnt
);

    localparam int SW  = 32 * SEED_WORDS;
    localparam int LW  = clog2_min1(RDI_W / COEF_W);
    localparam int CW  = clog2_min1(N);
    localparam int AW  = clog2_min1(N * NUM_POLY);
    localparam int PW  = clog2_min1(NUM_POLY);
    localparam int BAW = clog2_min1(SEED_WORDS);
    localparam int LCW = clog2_min1(SEED_WORDS + 1);

    localparam logic [2:0] S_IDLE      = GS_IDLE;
    localparam logic [2:0] S_LOAD_SEED = GS_LOAD_SEED;
    localparam logic [2:0] S_RESEED    = GS_RESEED;
    localparam logic [2:0] S_WAIT_RDI  = GS_WAIT_RDI;
    localparam logic [2:0] S_PARSE     = GS_PARSE;

    logic [2:0]        state;
    logic [LCW-1:0]    ld_cnt;
    logic [LCW-1:0]    ld_word;
    logic [LCW-1:0]    ld_next;
    logic [7:0]        base_top;
    logic [PW-1:0]     p;
    logic [CW-1:0]     ctr;
    logic [LW-1:0]     lane_idx;
    logic [AW-1:0]     addr_now;
    logic              blk_load;
    logic [COEF_W-1:0] lane;
    logic              lane_accept;
    logic              lane_last;

    // Handshake strobe, write address and seed-load word indices.
    always_comb begin
        blk_load = (state == S_WAIT_RDI) && rdi_valid && rdi_ready;
        addr_now = AW'(ctr) | (AW'(p) << CW);
        ld_word  = ld_cnt - 1'b1;
        ld_next  = ld_cnt + 1'b1;
    end

    gen_a_lane_buf #(
        .COEF_W  (COEF_W),
        .RDI_W   (RDI_W),
        .Q_BOUND (Q_BOUND),
        .LW      (LW)
    ) u_lane_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (blk_load),
        .rdi_data (rdi_data),
        .lane_idx (lane_idx),
        .lane     (lane),
        .accept   (lane_accept),
        .last     (lane_last)
    );

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ld_cnt     <= '0;
            base_top   <= '0;
            p          <= '0;
            ctr        <= '0;
            lane_idx   <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            byte_addr  <= '0;
            seed       <= '0;
            reseed     <= 1'b0;
            rdi_ready  <= 1'b0;
            poly_wea   <= 1'b0;
            poly_addra <= '0;
            poly_dia   <= '0;
            rej_cnt    <= '0;
        end else begin
            poly_wea <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD_SEED;
                        busy      <= 1'b1;
                        rej_cnt   <= '0;
                        p         <= '0;
                        ctr       <= '0;
                        ld_cnt    <= '0;
                        byte_addr <= '0;
                    end
                end
                S_LOAD_SEED: begin
                    // Data for the address issued last cycle is on byte_do now.
                    if (ld_cnt != '0) begin
                        seed[32*ld_word +: 32] <= byte_do;
                        if (ld_word == LCW'(SEED_WORDS - 1)) begin
                            base_top <= byte_do[31:24];
                        end
                    end
                    if (ld_cnt == LCW'(SEED_WORDS)) begin
                        state     <= S_RESEED;
                        reseed    <= 1'b1;
                        byte_addr <= '0;
                    end else begin
                        ld_cnt    <= ld_next;
                        byte_addr <= (ld_next < LCW'(SEED_WORDS)) ? BAW'(ld_next) : '0;
                    end
                end
                S_RESEED: begin
                    if (reseed_ack) begin
                        reseed    <= 1'b0;
                        rdi_ready <= 1'b1;
                        state     <= S_WAIT_RDI;
                    end
                end
                S_WAIT_RDI: begin
                    if (blk_load) begin
                        rdi_ready <= 1'b0;
                        lane_idx  <= '0;
                        state     <= S_PARSE;
                    end
                end
                S_PARSE: begin
                    lane_idx <= lane_idx + 1'b1;
                    if (lane_accept) begin
                        poly_wea   <= 1'b1;
                        poly_addra <= addr_now;
                        poly_dia   <= lane;
                        if (ctr == CW'(N - 1)) begin
                            // Polynomial complete: leftover lanes of this block are dropped.
                            ctr <= '0;
                            if (p == PW'(NUM_POLY - 1)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                p      <= p + 1'b1;
                                reseed <= 1'b1;
                                seed[SW-1 -: 8] <= base_top ^ (8'(p) + 8'd1);
                                state  <= S_RESEED;
                            end
                        end else begin
                            ctr <= ctr + 1'b1;
                            if (lane_last) begin
                                rdi_ready <= 1'b1;
                                state     <= S_WAIT_RDI;
                            end
                        end
                    end else begin
                        if (rej_cnt != 16'hFFFF) begin
                            rej_cnt <= rej_cnt + 1'b1;
                        end
                        if (lane_last) begin
                            rdi_ready <= 1'b1;
                            state     <= S_WAIT_RDI;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_a_multi.sv
// Directed bench for gen_a_multi with N=16, NUM_POLY=2, 8 lanes per block.
module tb_gen_a_multi;

    logic         clk;
    logic         rst;
    logic         start;
    logic         done;
    logic         busy;
    logic [2:0]   byte_addr;
    logic [31:0]  byte_do;
    logic [255:0] seed;
    logic         reseed;
    logic         reseed_ack;
    logic [127:0] rdi_data;
    logic         rdi_valid;
    logic         rdi_ready;
    logic         poly_wea;
    logic [4:0]   poly_addra;
    logic [15:0]  poly_dia;
    logic [15:0]  rej_cnt;

    gen_a_multi #(
        .N          (16),
        .NUM_POLY   (2),
        .COEF_W     (16),
        .RDI_W      (128),
        .SEED_WORDS (8),
        .Q_BOUND    (61445)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .byte_addr  (byte_addr),
        .byte_do    (byte_do),
        .seed       (seed),
        .reseed     (reseed),
        .reseed_ack (reseed_ack),
        .rdi_data   (rdi_data),
        .rdi_valid  (rdi_valid),
        .rdi_ready  (rdi_ready),
        .poly_wea   (poly_wea),
        .poly_addra (poly_addra),
        .poly_dia   (poly_dia),
        .rej_cnt    (rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  seed_mem [8];
    logic [127:0] blk_q [$];
    logic [4:0]   wa_q [$];
    logic [15:0]  wd_q [$];
    logic [255:0] seed_q [$];
    int           len_q [$];
    int           done_cnt = 0;
    int           done_on_last = 0;
    int           early_rdy = 0;
    int           rs_len = 0;
    logic         rs_prev = 1'b0;
    logic         busy_mid;
    int           pass_cnt = 0;
    int           tot_cnt = 0;

    // Seed RAM with one cycle read latency.
    always @(posedge clk) byte_do <= seed_mem[byte_addr];

    // Observe writes, done pulses and reseed handshakes.
    always @(negedge clk) begin
        if (poly_wea) begin
            wa_q.push_back(poly_addra);
            wd_q.push_back(poly_dia);
        end
        if (done) begin
            done_cnt++;
            if (poly_wea && poly_addra == 5'd31) done_on_last++;
        end
        if (reseed && !rs_prev) seed_q.push_back(seed);
        if (reseed) rs_len++;
        else if (rs_prev) begin
            len_q.push_back(rs_len);
            rs_len = 0;
        end
        if (rdi_ready && reseed) early_rdy++;
        rs_prev = reseed;
    end

    function automatic logic [127:0] mk_seq(input logic [15:0] s);
        logic [127:0] b;
        for (int i = 0; i < 8; i++) b[i*16 +: 16] = s + 16'(i);
        return b;
    endfunction

    function automatic logic [127:0] mk_alt(input logic [15:0] ev, input logic [15:0] od);
        logic [127:0] b;
        for (int i = 0; i < 8; i++) b[i*16 +: 16] = (i % 2 == 0) ? ev : od;
        return b;
    endfunction

    function automatic logic [127:0] mk8(input logic [15:0] l0, input logic [15:0] l1,
                                         input logic [15:0] l2, input logic [15:0] l3,
                                         input logic [15:0] l4, input logic [15:0] l5,
                                         input logic [15:0] l6, input logic [15:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        seed_q.delete();
        len_q.delete();
        early_rdy = 0;
    endtask

    // Start a run and act as PRNG until done or the cycle budget runs out.
    task automatic run_gen(input int ack_delay, input int stall_at, input int stall_len,
                           input int poke_at, output int ncyc);
        int rs_cnt;
        int blk;
        rs_cnt = 0;
        blk    = 0;
        ncyc   = -1;
        busy_mid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reseed_ack = 1'b0;
            rdi_valid  = 1'b0;
            start      = (cyc == poke_at);
            if (cyc == 2) busy_mid = busy;
            if (reseed) begin
                if (rs_cnt >= ack_delay) begin
                    reseed_ack = 1'b1;
                    rs_cnt = 0;
                end else begin
                    rs_cnt++;
                end
            end
            if (rdi_ready && blk < blk_q.size() &&
                !(cyc >= stall_at && cyc < stall_at + stall_len)) begin
                rdi_valid = 1'b1;
                rdi_data  = blk_q[blk];
                blk++;
            end
            @(negedge clk);
            if (done) begin
                ncyc = cyc;
                break;
            end
        end
        reseed_ack = 1'b0;
        rdi_valid  = 1'b0;
        start      = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        tot_cnt++; if (done !== 1'b0 || poly_wea !== 1'b0) $display("FAIL reset_done_wea got %b%b exp 00", done, poly_wea); else pass_cnt++;
        tot_cnt++; if (reseed !== 1'b0 || rdi_ready !== 1'b0) $display("FAIL reset_handshake got %b%b exp 00", reseed, rdi_ready); else pass_cnt++;
        tot_cnt++; if (seed !== 256'd0) $display("FAIL reset_seed got %h exp 0", seed); else pass_cnt++;
        tot_cnt++; if (rej_cnt !== 16'd0 || poly_addra !== 5'd0) $display("FAIL reset_cnt_addr got %h/%h exp 0/0", rej_cnt, poly_addra); else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int nc;
        int bad;
        int d0;
        int dl0;
        clear_obs();
        d0  = done_cnt;
        dl0 = done_on_last;
        blk_q = {mk_seq(16'd0), mk_seq(16'd8), mk_seq(16'd16), mk_seq(16'd24)};
        run_gen(0, -1, 0, -1, nc);
        tot_cnt++; if (nc < 0) $display("FAIL basic_timeout got no done exp done"); else pass_cnt++;
        tot_cnt++; if (wa_q.size() !== 32) $display("FAIL basic_wr_count got %0d exp 32", wa_q.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 5'(i) || wd_q[i] !== 16'(i)) bad++;
        tot_cnt++; if (bad !== 0) $display("FAIL basic_addr_data got %0d bad writes exp 0", bad); else pass_cnt++;
        tot_cnt++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_count got %0d exp 1", done_cnt - d0); else pass_cnt++;
        tot_cnt++; if (done_on_last - dl0 !== 1) $display("FAIL basic_done_with_last got %0d exp 1", done_on_last - dl0); else pass_cnt++;
        tot_cnt++; if (rej_cnt !== 16'd0) $display("FAIL basic_rej got %0d exp 0", rej_cnt); else pass_cnt++;
        tot_cnt++; if (busy_mid !== 1'b1) $display("FAIL basic_busy_mid got %b exp 1", busy_mid); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0 || rdi_ready !== 1'b0) $display("FAIL basic_idle_after got %b%b exp 00", busy, rdi_ready); else pass_cnt++;
        tot_cnt++; if (len_q.size() !== 2 || (len_q.size() == 2 && (len_q[0] !== 1 || len_q[1] !== 1)))
            $display("FAIL basic_reseed_single got %0d handshakes exp 2 of length 1", len_q.size()); else pass_cnt++;
    endtask

    task automatic test_reject();
        int nc;
        int bad;
        clear_obs();
        blk_q.delete();
        for (int i = 0; i < 7; i++) blk_q.push_back(mk_alt(16'hF005, 16'hF004));
        blk_q.push_back(mk_alt(16'hFFFF, 16'hF004));
        run_gen(0, -1, 0, -1, nc);
        tot_cnt++; if (nc < 0) $display("FAIL reject_timeout got no done exp done"); else pass_cnt++;
        tot_cnt++; if (wa_q.size() !== 32) $display("FAIL reject_wr_count got %0d exp 32", wa_q.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 5'(i) || wd_q[i] !== 16'hF004) bad++;
        tot_cnt++; if (bad !== 0) $display("FAIL reject_data got %0d bad writes exp 0", bad); else pass_cnt++;
        tot_cnt++; if (rej_cnt !== 16'd32) $display("FAIL reject_rej_cnt got %0d exp 32", rej_cnt); else pass_cnt++;
    endtask

    task automatic test_seed_discard();
        int nc;
        int bad;
        logic [255:0] exp_seed;
        logic [255:0] exp_seed1;
        clear_obs();
        for (int k = 0; k < 8; k++) exp_seed[32*k +: 32] = 32'h01010101 * (k + 1);
        exp_seed1 = exp_seed;
        exp_seed1[255:248] = 8'h09;
        blk_q = {mk8(16'd0, 16'd1, 16'd2, 16'd3, 16'hF005, 16'hF005, 16'd4, 16'd5),
                 mk_seq(16'd6),
                 mk8(16'd14, 16'd15, 16'hF005, 16'hF005, 16'h7777, 16'h7777, 16'hF005, 16'd0),
                 mk_seq(16'd16), mk_seq(16'd24)};
        run_gen(5, -1, 0, -1, nc);
        tot_cnt++; if (nc < 0) $display("FAIL seed_timeout got no done exp done"); else pass_cnt++;
        tot_cnt++; if (seed_q.size() < 1 || seed_q[0] !== exp_seed)
            $display("FAIL seed_poly0 got %h exp %h", (seed_q.size() > 0) ? seed_q[0] : 256'd0, exp_seed); else pass_cnt++;
        tot_cnt++; if (seed_q.size() < 2 || seed_q[1] !== exp_seed1)
            $display("FAIL seed_poly1 got %h exp %h", (seed_q.size() > 1) ? seed_q[1] : 256'd0, exp_seed1); else pass_cnt++;
        tot_cnt++; if (len_q.size() < 2 || len_q[0] !== 6 || len_q[1] !== 6)
            $display("FAIL seed_reseed_len got %0d entries first %0d exp 2 of 6", len_q.size(), (len_q.size() > 0) ? len_q[0] : -1); else pass_cnt++;
        tot_cnt++; if (early_rdy !== 0) $display("FAIL seed_early_ready got %0d exp 0", early_rdy); else pass_cnt++;
        tot_cnt++; if (wa_q.size() !== 32) $display("FAIL discard_wr_count got %0d exp 32", wa_q.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 5'(i) || wd_q[i] !== 16'(i)) bad++;
        tot_cnt++; if (bad !== 0) $display("FAIL discard_addr_data got %0d bad writes exp 0", bad); else pass_cnt++;
        tot_cnt++; if (rej_cnt !== 16'd2) $display("FAIL discard_rej_cnt got %0d exp 2", rej_cnt); else pass_cnt++;
    endtask

    task automatic test_stall_reset();
        int fed;
        int d0;
        int n_ok;
        clear_obs();
        d0  = done_cnt;
        fed = 0;
        n_ok = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (fed == 1 && rdi_ready) begin
                n_ok = 1;
                break;
            end
            reseed_ack = reseed;
            rdi_valid  = 1'b0;
            if (rdi_ready && fed == 0) begin
                rdi_valid = 1'b1;
                rdi_data  = mk_seq(16'd0);
                fed = 1;
            end
            @(negedge clk);
        end
        reseed_ack = 1'b0;
        rdi_valid  = 1'b0;
        tot_cnt++; if (n_ok !== 1) $display("FAIL stall_first_block got no ready exp ready"); else pass_cnt++;
        repeat (10) @(negedge clk);
        tot_cnt++; if (wa_q.size() !== 8) $display("FAIL stall_no_writes got %0d exp 8", wa_q.size()); else pass_cnt++;
        tot_cnt++; if (rdi_ready !== 1'b1) $display("FAIL stall_ready_held got %b exp 1", rdi_ready); else pass_cnt++;
        rdi_valid = 1'b1;
        rdi_data  = mk_seq(16'd8);
        @(negedge clk);
        rdi_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tot_cnt++; if (poly_wea !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_ctrl got wea %b busy %b done %b exp 000", poly_wea, busy, done); else pass_cnt++;
        tot_cnt++; if (poly_addra !== 5'd0 || poly_dia !== 16'd0 || seed !== 256'd0)
            $display("FAIL rst_mid_data got addr %h dia %h seed %h exp 0", poly_addra, poly_dia, seed); else pass_cnt++;
        tot_cnt++; if (rdi_ready !== 1'b0 || reseed !== 1'b0 || byte_addr !== 3'd0)
            $display("FAIL rst_mid_iface got %b%b%h exp 000", rdi_ready, reseed, byte_addr); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        tot_cnt++; if (done_cnt !== d0) $display("FAIL rst_no_done got %0d exp %0d", done_cnt, d0); else pass_cnt++;
        tot_cnt++; if (wa_q.size() !== 9) $display("FAIL rst_writes got %0d exp 9", wa_q.size()); else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int nc;
        int d0;
        clear_obs();
        d0 = done_cnt;
        blk_q = {mk_seq(16'd0), mk_seq(16'd8), mk_seq(16'd16), mk_seq(16'd24)};
        run_gen(0, -1, 0, 20, nc);
        tot_cnt++; if (nc < 0) $display("FAIL busy_start_timeout got no done exp done"); else pass_cnt++;
        tot_cnt++; if (wa_q.size() !== 32) $display("FAIL busy_start_wr_count got %0d exp 32", wa_q.size()); else pass_cnt++;
        tot_cnt++; if (done_cnt - d0 !== 1) $display("FAIL busy_start_done got %0d exp 1", done_cnt - d0); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL busy_start_idle got %b exp 0", busy); else pass_cnt++;
    endtask

    initial begin
        start      = 1'b0;
        reseed_ack = 1'b0;
        rdi_valid  = 1'b0;
        rdi_data   = '0;
        rst        = 1'b1;
        for (int k = 0; k < 8; k++) seed_mem[k] = 32'h01010101 * (k + 1);
        test_reset();
        test_basic();
        test_reject();
        test_seed_discard();
        test_stall_reset();
        test_start_while_busy();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
